texture_loader: RTL and testbench
=================================

# texture_loader

Sequencer that streams sprite textures from external SDRAM into the sprite renderer's texture RAMs at start-up. On a start pulse it issues one burst read request per texture (bird, pipe, base), accepts the returned words over a valid/ready stream, and drives the renderer's write ports with sequential addresses. It sits between the SDRAM read controller and the sprite renderer, entirely in the `bird_load_clk` (50 MHz) domain.

## Interface
Parameters:
- BIRD_WORDS, 5250: words in the bird texture (3 frames × 50×35).
- PIPE_WORDS, 40000: words in the pipe texture (80×500). All are sent; the sink filters.
- BASE_WORDS, 4800: words in the base texture (32×150).
- BIRD_SRC_ADDR, 24'h000000: SDRAM word address of the bird texture.
- PIPE_SRC_ADDR, 24'h002000: SDRAM word address of the pipe texture.
- BASE_SRC_ADDR, 24'h00C000: SDRAM word address of the base texture.

Ports:
- bird_load_clk  in  1  clock (50 MHz)
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse that begins a full load sequence
- rd_req  out  1  one-cycle burst request to the SDRAM reader
- rd_addr  out  24  burst start word address; valid while rd_req=1
- rd_len  out  16  burst length in words; valid while rd_req=1
- rd_ack  in  1  reader accepted the request
- src_valid  in  1  stream word valid
- src_data  in  16  stream word
- src_ready  out  1  loader accepts the stream word
- bird_load_en  out  1  bird RAM write enable
- bird_load_addr  out  13  bird RAM write address
- bird_load_data  out  16  write data, shared by all three RAMs
- pipe_load_en  out  1  pipe RAM write enable
- pipe_load_addr  out  16  pipe RAM write address
- base_load_en  out  1  base RAM write enable
- base_load_addr  out  14  base RAM write address
- busy  out  1  a load sequence is in progress
- load_done  out  1  all three textures have been written; held high until the next accepted start

## Operation
- States: IDLE, REQ_BIRD, RX_BIRD, REQ_PIPE, RX_PIPE, REQ_BASE, RX_BASE, DONE.
- IDLE/DONE, start=1: clear the word counter and load_done, then go to REQ_BIRD.
- start is ignored in every other state.
- REQ_x: hold rd_req=1 with rd_addr=x_SRC_ADDR and rd_len=x_WORDS until the cycle in which rd_ack=1, then go to RX_x with the counter at 0.
- RX_x: src_ready=1. A transfer occurs on each cycle where src_valid=1 and src_ready=1.
  - On a transfer, the next cycle shows x_load_en=1, x_load_addr=counter, and bird_load_data=src_data. The counter then increments.
  - The transfer with counter=x_WORDS-1 ends the state. The FSM goes to the next REQ state, or to DONE after base.
- src_ready=0 in every non-RX state. Words offered outside RX are not consumed.
- At most one of the three enables is high in any cycle. Addresses and data hold their last value when the enables are low.
- Counter width is 16 bits. Addresses are the counter truncated to the port width; the truncation never wraps for the default sizes.
- busy=1 in the REQ and RX states. DONE sets load_done=1. From DONE, a start restarts the whole sequence.
- Deasserting rst_n mid-sequence returns the block to IDLE immediately. Partially written RAM contents are not cleared.

## Timing
- Reset values:
  - rd_req=0, rd_addr=0, rd_len=0, src_ready=0
  - all enables=0, all addresses=0, bird_load_data=0
  - busy=0, load_done=0, state=IDLE
- start in cycle N gives rd_req=1 in cycle N+1.
- Write latency is 1 cycle from the accepted transfer to the enable.
- Throughput is one word per cycle when src_valid is held high.
- The last write of a texture and rd_req of the next texture occur in the same cycle (the cycle after the final transfer).
- load_done rises 1 cycle after the final base write cycle.
- rd_req falls in the cycle after rd_ack. rd_ack while rd_req=0 is ignored.

## Test plan
- Full load, src_valid always high, rd_ack 2 cycles after each request:
  - exactly 5250 bird writes at addresses 0..5249, then 40000 pipe writes at 0..39999, then 4800 base writes at 0..4799
  - data equals the stream order
  - load_done=1 after the final base write, busy=0
- Random src_valid gaps (about 30% idle):
  - the same address/data sequence, with no duplicated or skipped addresses
  - an enable is never high in a cycle without a preceding transfer
- start pulsed during RX_PIPE: ignored, and the sequence finishes normally. A start in DONE restarts: load_done=0 and rd_req with rd_addr=BIRD_SRC_ADDR.
- rst_n low at bird word 100: all outputs return to their reset values asynchronously. A new start begins again at bird address 0.
- src_valid high in IDLE or during REQ states: src_ready=0 and no writes occur.
- Boundary at the end of the bird texture: the word at counter 5249 writes bird addr 5249. The next cycle has rd_req=1 with rd_addr=PIPE_SRC_ADDR and rd_len=40000, and no pipe write occurs before rd_ack.

Source files
------------

// File: rtl/texture_loader_if.sv
// texture_loader_if
// Bundles the three buses around the texture loader:
//   rd_*     : burst request to the SDRAM reader (rd_req/rd_addr/rd_len out, rd_ack in)
//   src_*    : returned word stream (src_valid/src_data in, src_ready out)
//   *_load_* : write ports into the renderer's bird/pipe/base texture RAMs
// master = the loader, slave = the surrounding SDRAM reader + renderer.
interface texture_loader_if;
  logic        rd_req;
  logic [23:0] rd_addr;
  logic [15:0] rd_len;
  logic        rd_ack;

  logic        src_valid;
  logic [15:0] src_data;
  logic        src_ready;

  logic        bird_load_en;
  logic [12:0] bird_load_addr;
  logic [15:0] bird_load_data;
  logic        pipe_load_en;
  logic [15:0] pipe_load_addr;
  logic        base_load_en;
  logic [13:0] base_load_addr;

  modport master (
    output rd_req, rd_addr, rd_len,
    input  rd_ack,
    input  src_valid, src_data,
    output src_ready,
    output bird_load_en, bird_load_addr, bird_load_data,
    output pipe_load_en, pipe_load_addr,
    output base_load_en, base_load_addr
  );

  modport slave (
    input  rd_req, rd_addr, rd_len,
    output rd_ack,
    output src_valid, src_data,
    input  src_ready,
    input  bird_load_en, bird_load_addr, bird_load_data,
    input  pipe_load_en, pipe_load_addr,
    input  base_load_en, base_load_addr
  );
endinterface

// File: rtl/texture_loader.sv
// texture_loader
// Start-up sequencer: on a start pulse, requests one SDRAM burst per texture
// (bird, pipe, base), accepts the returned words and writes them into the
// renderer's texture RAMs at sequential addresses.
// Ports:
//   bird_load_clk : clock (50 MHz)
//   rst_n         : asynchronous active-low reset
//   start         : one-cycle pulse, honoured only in IDLE/DONE
//   bus           : texture_loader_if.master (SDRAM request, word stream, RAM writes)
//   busy          : a request or receive phase is in progress
//   load_done     : all textures written; held until the next accepted start
//
// state    | meaning
// IDLE     | waiting for start after reset
// REQ_BIRD | rd_req held for the bird burst until rd_ack
// RX_BIRD  | receiving bird words
// REQ_PIPE | rd_req held for the pipe burst until rd_ack
// RX_PIPE  | receiving pipe words
// REQ_BASE | rd_req held for the base burst until rd_ack
// RX_BASE  | receiving base words
// DONE     | all textures loaded, waiting for a restart
module texture_loader #(
  parameter int unsigned BIRD_WORDS    = 5250,
  parameter int unsigned PIPE_WORDS    = 40000,
  parameter int unsigned BASE_WORDS    = 4800,
  parameter logic [23:0] BIRD_SRC_ADDR = 24'h000000,
  parameter logic [23:0] PIPE_SRC_ADDR = 24'h002000,
  parameter logic [23:0] BASE_SRC_ADDR = 24'h00C000
) (
  input  logic             bird_load_clk,
  input  logic             rst_n,
  input  logic             start,
  texture_loader_if.master bus,
  output logic             busy,
  output logic             load_done
);

  localparam logic [15:0] BIRD_LAST = 16'(BIRD_WORDS - 1);
  localparam logic [15:0] PIPE_LAST = 16'(PIPE_WORDS - 1);
  localparam logic [15:0] BASE_LAST = 16'(BASE_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE, REQ_BIRD, RX_BIRD, REQ_PIPE, RX_PIPE, REQ_BASE, RX_BASE, DONE
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] word_cnt;
  logic        xfer;
  logic        start_ok;

  assign xfer     = bus.src_valid & bus.src_ready;
  assign start_ok = start & ((state == IDLE) | (state == DONE));

  always_ff @(posedge bird_load_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.rd_req    = 1'b0;
    bus.rd_addr   = '0;
    bus.rd_len    = '0;
    bus.src_ready = 1'b0;
    busy          = 1'b0;
    case (state)
      IDLE, DONE: if (start) state_nxt = REQ_BIRD;
      REQ_BIRD: begin
        busy        = 1'b1;
        bus.rd_req  = 1'b1;
        bus.rd_addr = BIRD_SRC_ADDR;
        bus.rd_len  = 16'(BIRD_WORDS);
        if (bus.rd_ack) state_nxt = RX_BIRD;
      end
      RX_BIRD: begin
        busy          = 1'b1;
        bus.src_ready = 1'b1;
        if (bus.src_valid && word_cnt == BIRD_LAST) state_nxt = REQ_PIPE;
      end
      REQ_PIPE: begin
        busy        = 1'b1;
        bus.rd_req  = 1'b1;
        bus.rd_addr = PIPE_SRC_ADDR;
        bus.rd_len  = 16'(PIPE_WORDS);
        if (bus.rd_ack) state_nxt = RX_PIPE;
      end
      RX_PIPE: begin
        busy          = 1'b1;
        bus.src_ready = 1'b1;
        if (bus.src_valid && word_cnt == PIPE_LAST) state_nxt = REQ_BASE;
      end
      REQ_BASE: begin
        busy        = 1'b1;
        bus.rd_req  = 1'b1;
        bus.rd_addr = BASE_SRC_ADDR;
        bus.rd_len  = 16'(BASE_WORDS);
        if (bus.rd_ack) state_nxt = RX_BASE;
      end
      RX_BASE: begin
        busy          = 1'b1;
        bus.src_ready = 1'b1;
        if (bus.src_valid && word_cnt == BASE_LAST) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Write port registers: one cycle of latency from the accepted word.
  // Addresses and data are only updated on a transfer so they hold otherwise.
  always_ff @(posedge bird_load_clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt           <= '0;
      load_done          <= 1'b0;
      bus.bird_load_en   <= 1'b0;
      bus.bird_load_addr <= '0;
      bus.bird_load_data <= '0;
      bus.pipe_load_en   <= 1'b0;
      bus.pipe_load_addr <= '0;
      bus.base_load_en   <= 1'b0;
      bus.base_load_addr <= '0;
    end else begin
      bus.bird_load_en <= 1'b0;
      bus.pipe_load_en <= 1'b0;
      bus.base_load_en <= 1'b0;

      // load_done follows DONE by a cycle so it rises after the last base write.
      if (start_ok) begin
        word_cnt  <= '0;
        load_done <= 1'b0;
      end else if (state == DONE) begin
        load_done <= 1'b1;
      end

      if (bus.rd_req && bus.rd_ack) word_cnt <= '0;

      if (xfer) begin
        word_cnt           <= word_cnt + 16'd1;
        bus.bird_load_data <= bus.src_data;
        case (state)
          RX_BIRD: begin
            bus.bird_load_en   <= 1'b1;
            bus.bird_load_addr <= word_cnt[12:0];
          end
          RX_PIPE: begin
            bus.pipe_load_en   <= 1'b1;
            bus.pipe_load_addr <= word_cnt;
          end
          RX_BASE: begin
            bus.base_load_en   <= 1'b1;
            bus.base_load_addr <= word_cnt[13:0];
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_texture_loader.sv
// tb_texture_loader
// Self-checking bench for texture_loader with reduced texture sizes.
// A transaction-level model tracks the accepted word stream in a queue and
// the expected (texture, address) write order; bursts are acknowledged after
// a configurable delay and stream gaps come from $urandom.
module tb_texture_loader;
  localparam int BW = 24;
  localparam int PW = 40;
  localparam int SW = 16;
  localparam logic [23:0] SRC   [3] = '{24'h000000, 24'h002000, 24'h00C000};
  localparam int          WORDS [3] = '{BW, PW, SW};

  logic bird_load_clk;
  logic rst_n;
  logic start;
  logic busy;
  logic load_done;

  texture_loader_if tl_if ();

  texture_loader #(
    .BIRD_WORDS(BW), .PIPE_WORDS(PW), .BASE_WORDS(SW),
    .BIRD_SRC_ADDR(SRC[0]), .PIPE_SRC_ADDR(SRC[1]), .BASE_SRC_ADDR(SRC[2])
  ) dut (
    .bird_load_clk(bird_load_clk),
    .rst_n        (rst_n),
    .start        (start),
    .bus          (tl_if.master),
    .busy         (busy),
    .load_done    (load_done)
  );

  initial bird_load_clk = 1'b0;
  always #10 bird_load_clk = ~bird_load_clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [15:0] acc_q[$];
  logic [15:0] last_data;
  int wr_tex, wr_addr, req_tex, req_cycles;
  int idle_pct, ack_delay;
  bit xfer_prev, start_prev, ack_prev, start_ign, done_pend, finished, running;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string t);
    chk({t, "_rd_req"},    32'(tl_if.rd_req), 0);
    chk({t, "_rd_addr"},   32'(tl_if.rd_addr), 0);
    chk({t, "_rd_len"},    32'(tl_if.rd_len), 0);
    chk({t, "_src_ready"}, 32'(tl_if.src_ready), 0);
    chk({t, "_enables"},   32'({tl_if.base_load_en, tl_if.pipe_load_en, tl_if.bird_load_en}), 0);
    chk({t, "_addrs"},     32'(tl_if.bird_load_addr) | 32'(tl_if.pipe_load_addr) | 32'(tl_if.base_load_addr), 0);
    chk({t, "_data"},      32'(tl_if.bird_load_data), 0);
    chk({t, "_busy"},      32'(busy), 0);
    chk({t, "_load_done"}, 32'(load_done), 0);
  endtask

  // One clock cycle: sample/check at the falling edge, then drive inputs.
  task automatic step();
    logic [2:0]  en;
    int          hot;
    logic [31:0] addr;
    logic [15:0] exp_d;
    @(negedge bird_load_clk);
    start         = 1'b0;
    tl_if.rd_ack  = 1'b0;
    en = {tl_if.base_load_en, tl_if.pipe_load_en, tl_if.bird_load_en};
    chk("enable_vs_transfer", 32'($countones(en)), 32'(xfer_prev));

    if (start_prev) begin
      chk("start_rd_req",    32'(tl_if.rd_req), 1);
      chk("start_rd_addr",   32'(tl_if.rd_addr), 32'(SRC[0]));
      chk("start_load_done", 32'(load_done), 0);
      running    = 1'b1;
      start_prev = 1'b0;
    end
    if (start_ign) begin
      chk("start_ignored_rd_req", 32'(tl_if.rd_req), 0);
      start_ign = 1'b0;
    end
    if (ack_prev) chk("rd_req_fall", 32'(tl_if.rd_req), 0);

    if (done_pend) begin
      chk("load_done_rise", 32'(load_done), 1);
      done_pend = 1'b0;
      finished  = 1'b1;
    end

    if (xfer_prev) begin
      if (wr_tex > 2) begin
        chk("write_after_done", 32'(en), 0);
      end else begin
        hot  = tl_if.bird_load_en ? 0 : tl_if.pipe_load_en ? 1 : tl_if.base_load_en ? 2 : 3;
        addr = (hot == 0) ? 32'(tl_if.bird_load_addr) :
               (hot == 1) ? 32'(tl_if.pipe_load_addr) : 32'(tl_if.base_load_addr);
        exp_d = (acc_q.size() > 0) ? acc_q.pop_front() : 16'hxxxx;
        chk("wr_texture", 32'(hot), 32'(wr_tex));
        chk("wr_addr", addr, 32'(wr_addr));
        chk("wr_data", 32'(tl_if.bird_load_data), 32'(exp_d));
        last_data = exp_d;
        wr_addr++;
        if (wr_addr == WORDS[wr_tex]) begin
          wr_addr = 0;
          if (wr_tex < 2) begin
            wr_tex++;
            chk("next_req_same_cycle", 32'(tl_if.rd_req), 1);
            chk("next_req_addr", 32'(tl_if.rd_addr), 32'(SRC[wr_tex]));
            chk("next_req_len", 32'(tl_if.rd_len), 32'(WORDS[wr_tex]));
          end else begin
            wr_tex = 3;
            chk("load_done_early", 32'(load_done), 0);
            done_pend = 1'b1;
          end
        end
      end
    end else if (running) begin
      chk("data_hold", 32'(tl_if.bird_load_data), 32'(last_data));
    end
    chk("busy", 32'(busy), 32'(running && wr_tex < 3));

    ack_prev = 1'b0;
    if (tl_if.rd_req) begin
      chk("src_ready_in_req", 32'(tl_if.src_ready), 0);
      if (req_tex > 2) begin
        chk("unexpected_req", 32'(tl_if.rd_req), 0);
      end else begin
        chk("rd_addr", 32'(tl_if.rd_addr), 32'(SRC[req_tex]));
        chk("rd_len",  32'(tl_if.rd_len),  32'(WORDS[req_tex]));
        req_cycles++;
        if (req_cycles > ack_delay) begin
          tl_if.rd_ack = 1'b1;
          ack_prev     = 1'b1;
          req_tex++;
          req_cycles   = 0;
        end
      end
    end else if ($urandom_range(99) < 15) begin
      tl_if.rd_ack = 1'b1;   // stray ack with no request pending
    end

    tl_if.src_valid = ($urandom_range(99) >= idle_pct);
    tl_if.src_data  = 16'($urandom);
    xfer_prev = tl_if.src_valid && tl_if.src_ready;
    if (xfer_prev) acc_q.push_back(tl_if.src_data);
  endtask

  task automatic run_load(input int gap, input int ack_dly, input bit mid_start, input int abort_at);
    int budget = 0;
    bit mid_done = 1'b0;
    wr_tex = 0; wr_addr = 0; req_tex = 0; req_cycles = 0;
    acc_q.delete();
    finished = 1'b0; done_pend = 1'b0;
    idle_pct = gap; ack_delay = ack_dly;
    start = 1'b1; start_prev = 1'b1;
    while (!finished && budget < 2000) begin
      step();
      budget++;
      if (mid_start && !mid_done && wr_tex == 1 && wr_addr == 5) begin
        start = 1'b1; start_ign = 1'b1; mid_done = 1'b1;
      end
      if (abort_at >= 0 && wr_tex == 0 && wr_addr == abort_at) begin
        #3 rst_n = 1'b0;
        #1 chk_reset("async_reset");
        tl_if.rd_ack = 1'b0; xfer_prev = 1'b0; start_prev = 1'b0; start_ign = 1'b0;
        ack_prev = 1'b0; running = 1'b0; last_data = '0;
        @(negedge bird_load_clk);
        chk_reset("held_reset");
        rst_n = 1'b1;
        return;
      end
    end
    chk("load_complete", 32'(finished), 1);
    if (mid_start) chk("mid_start_issued", 32'(mid_done), 1);
    running = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0;
    tl_if.rd_ack = 1'b0; tl_if.src_valid = 1'b0; tl_if.src_data = '0;
    xfer_prev = 0; start_prev = 0; ack_prev = 0; start_ign = 0;
    done_pend = 0; finished = 0; running = 0; last_data = '0;
    #25;
    chk_reset("por");
    @(negedge bird_load_clk);
    rst_n = 1'b1;

    tl_if.src_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge bird_load_clk);
      chk("idle_src_ready", 32'(tl_if.src_ready), 0);
      chk("idle_no_write", 32'({tl_if.base_load_en, tl_if.pipe_load_en, tl_if.bird_load_en}), 0);
    end

    run_load(0, 2, 1'b0, -1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("load_done_hold", 32'(load_done), 1);
    end

    run_load(30, 1 + int'($urandom_range(3)), 1'b1, -1);
    step();
    chk("done_after_restart", 32'(load_done), 1);

    run_load(30, 1, 1'b0, 10);
    run_load(30, 3, 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
